// File: rtl/screen_console_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : screen_pkg
// Purpose  : Shared geometry, control-code constants and writer state type
//            for the character-screen console writer.
// Revision : 1.0 - initial release
// ============================================================================
package screen_pkg;

  localparam int COLS         = 128;                  // power of two
  localparam int ROWS         = 80;
  localparam int SCREEN_DEPTH = COLS * ROWS;
  localparam int ADDR_W       = $clog2(SCREEN_DEPTH);
  localparam int COL_W        = $clog2(COLS);
  localparam int ROW_W        = ADDR_W - COL_W;       // cell address is {row, col}
  localparam int COPY_N       = (ROWS - 1) * COLS;    // cells moved by one scroll

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SCROLL_COPY  = 2'd1,
    ST_SCROLL_CLEAR = 2'd2,
    ST_CLEAR_ALL    = 2'd3
  } screen_wr_state_t;

endpackage
`default_nettype wire

// File: rtl/screen_console_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : screen_console_writer_if
// Purpose  : Byte-stream handshake plus screen-memory port of the console
//            writer, bundled with cursor/busy status.
//   slave  : the writer (consumes bytes, drives memory port and status)
//   master : the processor / memory side
// Revision : 1.0 - initial release
// ============================================================================
interface screen_console_writer_if;
  import screen_pkg::*;

  logic              in_valid;
  logic [7:0]        in_char;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata;
  logic [ROW_W-1:0]  cursor_row;
  logic [COL_W-1:0]  cursor_col;
  logic              busy;

  modport slave (
    input  in_valid, in_char, mem_rdata,
    output in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cursor_row, cursor_col, busy
  );

  modport master (
    output in_valid, in_char, mem_rdata,
    input  in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
           cursor_row, cursor_col, busy
  );
endinterface
`default_nettype wire

// File: rtl/screen_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : screen_console_writer
// Purpose  : Consumes ASCII bytes, writes them at the cursor into the screen
//            memory, interprets LF/CR/BS/FF and performs hardware scroll and
//            full-screen clear by sweeping the memory.
// Ports    : clk, rst_n (async, active low), bus (screen_console_writer_if
//            slave: byte handshake, memory write/read port, cursor, busy)
// Revision : 1.0 - initial release
// ============================================================================
module screen_console_writer
  import screen_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  screen_console_writer_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_cols     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] c_copy_n   = ADDR_W'(COPY_N);
  localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(SCREEN_DEPTH - 1);
  localparam logic [ROW_W-1:0]  c_row_last = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  c_col_last = COL_W'(COLS - 1);

  screen_wr_state_t  r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_copy, w_copy_nxt;   // write data comes from read port
  logic              w_newline;
  logic              w_printable;

  assign w_printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_raddr_nxt = r_raddr;
    w_cnt_nxt   = r_cnt;
    w_copy_nxt  = 1'b0;
    w_newline   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (w_printable) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = {r_row, r_col};
            w_wdata_nxt = bus.in_char;
            if (r_col == c_col_last) w_newline = 1'b1;
            else                     w_col_nxt = r_col + COL_W'(1);
          end else begin
            case (bus.in_char)
              CH_LF: w_newline = 1'b1;
              CH_CR: w_col_nxt = '0;
              CH_BS: begin
                if (r_col != '0) begin
                  w_col_nxt   = r_col - COL_W'(1);
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = {r_row, r_col - COL_W'(1)};
                  w_wdata_nxt = 8'h00;
                end
              end
              CH_FF: begin
                w_row_nxt   = '0;
                w_col_nxt   = '0;
                w_state_nxt = ST_CLEAR_ALL;
                w_we_nxt    = 1'b1;
                w_waddr_nxt = '0;
                w_wdata_nxt = 8'h00;
              end
              default: ;
            endcase
          end

          if (w_newline) begin
            w_col_nxt = '0;
            if (r_row == c_row_last) begin
              // Row 0 is about to be overwritten with row 1: prime the read
              // port so the first source byte arrives one cycle later.
              w_state_nxt = ST_SCROLL_COPY;
              w_cnt_nxt   = '0;
              w_raddr_nxt = c_cols;
            end else begin
              w_row_nxt = r_row + ROW_W'(1);
            end
          end
        end
      end

      ST_SCROLL_COPY: begin
        // Cycle k reads COLS+k; cycle k+1 writes that byte to k.
        if (r_cnt == c_copy_n) begin
          w_state_nxt = ST_SCROLL_CLEAR;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = c_copy_n;
          w_wdata_nxt = 8'h00;
          w_raddr_nxt = '0;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_cnt;
          w_copy_nxt  = 1'b1;
          w_cnt_nxt   = r_cnt + ADDR_W'(1);
          // Stop the read address before it runs past the last cell.
          w_raddr_nxt = (r_cnt == c_copy_n - ADDR_W'(1)) ? '0
                                                         : c_cols + r_cnt + ADDR_W'(1);
        end
      end

      ST_SCROLL_CLEAR, ST_CLEAR_ALL: begin
        // The write address itself is the sweep counter.
        if (r_waddr == c_last) begin
          w_state_nxt = ST_IDLE;
          w_waddr_nxt = '0;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_waddr + ADDR_W'(1);
          w_wdata_nxt = 8'h00;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 8'h00;
      r_raddr <= '0;
      r_cnt   <= '0;
      r_copy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_raddr <= w_raddr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_copy  <= w_copy_nxt;
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.mem_we     = r_we;
  assign bus.mem_waddr  = r_waddr;
  // Read data is already registered inside the memory, so copy writes pass
  // it straight through instead of spending another pipeline stage.
  assign bus.mem_wdata  = r_copy ? bus.mem_rdata : r_wdata;
  assign bus.mem_raddr  = r_raddr;
  assign bus.cursor_row = r_row;
  assign bus.cursor_col = r_col;

endmodule
`default_nettype wire

// File: tb/tb_screen_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_console_writer (+ screen_ram_dp memory model)
// Purpose  : Randomized scoreboard bench for the console writer.
// Revision : 1.0 - initial release
// ============================================================================
module screen_ram_dp
  import screen_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [SCREEN_DEPTH];
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

module tb_screen_console_writer;
  import screen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  screen_console_writer_if bus();

  screen_console_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  screen_ram_dp u_ram (
    .clk(clk), .we(bus.mem_we), .waddr(bus.mem_waddr), .wdata(bus.mem_wdata),
    .raddr(bus.mem_raddr), .rdata(bus.mem_rdata)
  );

  typedef struct { int addr; int data; } wr_t;
  wr_t        expq[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] scr [SCREEN_DEPTH];
  int         mrow = 0;
  int         mcol = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: screen as a plain 2-D text grid -------
  function automatic void push(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    expq.push_back(w);
    scr[a] = 8'(d);
  endfunction

  function automatic void model_newline();
    mcol = 0;
    if (mrow + 1 == ROWS) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          push(r * COLS + c, int'(scr[(r + 1) * COLS + c]));
      for (int c = 0; c < COLS; c++) push((ROWS - 1) * COLS + c, 0);
    end else begin
      mrow++;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(mrow * COLS + mcol, int'(c));
      mcol++;
      if (mcol == COLS) model_newline();
    end else if (c == CH_LF) begin
      model_newline();
    end else if (c == CH_CR) begin
      mcol = 0;
    end else if (c == CH_BS) begin
      if (mcol > 0) begin
        mcol--;
        push(mrow * COLS + mcol, 0);
      end
    end else if (c == CH_FF) begin
      mrow = 0;
      mcol = 0;
      for (int i = 0; i < SCREEN_DEPTH; i++) push(i, 0);
    end
  endfunction

  // ---------------- monitor ------------------------------------------------
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      check("ready_vs_busy", int'(bus.in_ready), int'(!bus.busy));
      if (bus.mem_we) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%0d expected=none",
                   bus.mem_waddr, bus.mem_wdata);
        end else begin
          w = expq.pop_front();
          check("wr_addr", int'(bus.mem_waddr), w.addr);
          check("wr_data", int'(bus.mem_wdata), w.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers (entered and left on a negedge) ------
  task automatic send(input logic [7:0] c, output int waited);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    waited = 0;
    while (!bus.in_ready && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout waited=%0d required=ready", waited);
      bus.in_valid = 1'b0;
      return;
    end
    model_byte(c);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] c);
    int dummy;
    send(c, dummy);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_cursor(input string name);
    check({name, "_row"}, int'(bus.cursor_row), mrow);
    check({name, "_col"}, int'(bus.cursor_col), mcol);
  endtask

  logic [7:0] rnd;

  initial begin
    int cyc;
    int bad;
    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(bus.in_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_we", int'(bus.mem_we), 0);
    check("rst_row", int'(bus.cursor_row), 0);
    check("rst_col", int'(bus.cursor_col), 0);

    // "AB"
    send1(8'h41);
    send1(8'h42);
    check("ab_row", int'(bus.cursor_row), 0);
    check("ab_col", int'(bus.cursor_col), 2);
    check("ab_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    check("ab_mem0", int'(u_ram.mem[0]), 8'h41);
    check("ab_mem1", int'(u_ram.mem[1]), 8'h42);

    // Clear interrupted by reset
    send1(CH_FF);
    check("ff_busy", int'(bus.busy), 1);
    check("ff_ready", int'(bus.in_ready), 0);
    repeat (3000) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_we", int'(bus.mem_we), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_waddr", int'(bus.mem_waddr), 0);
    check("midrst_row", int'(bus.cursor_row), 0);
    check("midrst_col", int'(bus.cursor_col), 0);
    expq.delete();
    mrow = 0;
    mcol = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", int'(bus.in_ready), 1);

    // Full clear
    send1(CH_FF);
    wait_idle(cyc);
    check("clear_cycles", cyc, SCREEN_DEPTH);
    check_cursor("clear");

    // One full row of printables
    for (int i = 0; i < COLS; i++) send1(8'($urandom_range(32, 126)));
    check_cursor("row128");
    check("row128_curs_r", int'(bus.cursor_row), 1);
    check("row128_busy", int'(bus.busy), 0);

    // Backspace at col 0 and mid-row
    send1(CH_LF);
    send1(CH_LF);
    send1(CH_BS);
    check("bs0_row", int'(bus.cursor_row), 3);
    check("bs0_col", int'(bus.cursor_col), 0);
    for (int i = 0; i < 4; i++) send1(8'($urandom_range(32, 126)));
    send1(CH_BS);
    check("bs4_row", int'(bus.cursor_row), 3);
    check("bs4_col", int'(bus.cursor_col), 3);
    repeat (2) @(negedge clk);
    check("bs4_mem387", int'(u_ram.mem[387]), 0);

    // Random mixed stream (no FF)
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       rnd = CH_LF;
        1:       rnd = CH_CR;
        2:       rnd = CH_BS;
        3: begin
          rnd = 8'($urandom_range(0, 255));
          if (rnd == CH_FF) rnd = 8'h00;
        end
        default: rnd = 8'($urandom_range(32, 126));
      endcase
      send1(rnd);
    end
    check_cursor("random");

    // Scroll: seed row 1 with 0x55, walk to (79,5), LF
    send1(CH_FF);
    wait_idle(cyc);
    send1(CH_LF);
    for (int i = 0; i < COLS; i++) send1(8'h55);
    for (int i = 0; i < ROWS - 3; i++) send1(CH_LF);
    for (int i = 0; i < 5; i++) send1(8'($urandom_range(32, 126)));
    check("prescroll_row", int'(bus.cursor_row), 79);
    check("prescroll_col", int'(bus.cursor_col), 5);
    send1(CH_LF);
    wait_idle(cyc);
    check("scroll_cycles", cyc, COPY_N + 1 + COLS);
    check("scroll_row", int'(bus.cursor_row), 79);
    check("scroll_col", int'(bus.cursor_col), 0);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < COLS; i++) if (u_ram.mem[i] != 8'h55) bad++;
    check("scroll_row0_bad", bad, 0);
    bad = 0;
    for (int i = COPY_N; i < SCREEN_DEPTH; i++) if (u_ram.mem[i] != 8'h00) bad++;
    check("scroll_lastrow_bad", bad, 0);

    // Hold in_valid through a scroll
    send1(CH_LF);
    send(8'h5A, cyc);
    check("hold_wait", cyc, COPY_N + 1 + COLS);
    check("hold_row", int'(bus.cursor_row), 79);
    check("hold_col", int'(bus.cursor_col), 1);
    repeat (2) @(negedge clk);
    check("hold_mem10112", int'(u_ram.mem[10112]), 8'h5A);

    repeat (5) @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/screen_console_writer.md
# screen_console_writer

Character-stream console that writes into the dual-port character screen memory, which the display side reads one byte per address with one-cycle synchronous latency. It accepts ASCII bytes from the processor over a valid/ready handshake, tracks a cursor, and interprets a small control-character set. It performs hardware scroll (row copy plus last-row clear) and full-screen clear by sweeping the memory. It sits between the processor's memory-mapped console port and the screen memory's write/read port.

## Interface
- COLS, 128, characters per row; must be a power of two.
- ROWS, 80, rows per screen.
- ADDR_W, 14, screen address width, equal to clog2(COLS*ROWS).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_char holds a byte to consume.
- in_char  input  8  ASCII byte.
- in_ready  output  1  writer can accept a byte this cycle.
- mem_we  output  1  write strobe to screen memory.
- mem_waddr  output  ADDR_W  write address.
- mem_wdata  output  8  write data.
- mem_raddr  output  ADDR_W  read address; used only during scroll.
- mem_rdata  input  8  read data, valid the cycle after mem_raddr is presented.
- cursor_row  output  7  current cursor row, 0..ROWS-1.
- cursor_col  output  7  current cursor column, 0..COLS-1.
- busy  output  1  a scroll or clear sweep is in progress.

## Operation
- States: IDLE, SCROLL_COPY, SCROLL_CLEAR, CLEAR_ALL.
- in_ready = 1 only in IDLE. A byte is accepted on an edge where in_valid && in_ready.
- Cell address = {row, col}, i.e. row*COLS + col; no multiplier.
- Accepted byte handling:
  - Printable, 0x20..0x7E: write the byte at the cursor, then col+1. If col was COLS-1, set col=0 and row+1.
  - 0x0A (LF): col=0, row+1.
  - 0x0D (CR): col=0.
  - 0x08 (BS): if col>0, col-1 and write 0x00 at the new position. At col 0, no effect.
  - 0x0C (FF): enter CLEAR_ALL; cursor goes to (0,0).
  - Any other byte: consumed with no effect.
- Scroll trigger: when row+1 would reach ROWS, row stays ROWS-1, col=0, and the state goes to SCROLL_COPY. This applies to a printable at the last column or an LF.
- SCROLL_COPY: counter k = 0..N-1 with N = (ROWS-1)*COLS.
  - Cycle k: mem_raddr = COLS+k.
  - Cycle k+1: mem_we=1, mem_waddr=k, mem_wdata=mem_rdata.
- SCROLL_CLEAR: writes 0x00 to addresses N..N+COLS-1, one per cycle, then goes to IDLE.
- CLEAR_ALL: writes 0x00 to addresses 0..COLS*ROWS-1, one per cycle, then goes to IDLE.
- busy = 1 in every state except IDLE.
- Reset, including mid-sweep: state IDLE, cursor (0,0), and all outputs 0 except in_ready, which is 1 after reset release. A partially completed sweep is abandoned; memory contents are not restored.

## Timing
- mem_* outputs are registered. A byte accepted at edge E produces its memory write in the cycle following E.
- Printable throughput is 1 byte/cycle with no scroll.
- Cursor outputs update at the accepting edge.
- When an accept triggers a sweep, in_ready drops in the cycle after the accepting edge.
  - The triggering printable's own write completes before the first copy write.
- Scroll occupancy: N+1 copy cycles (one pipeline bubble), plus COLS clear cycles. With defaults: 10112+1+128 = 10241 cycles.
- Clear occupancy: COLS*ROWS cycles; 10240 with defaults.
- Every sweep address stays within 0..COLS*ROWS-1; the counter never wraps past the last cell.

## Structure
- Shared package screen_pkg holds:
  - COLS, ROWS, SCREEN_DEPTH, ADDR_W.
  - Control-code constants CH_LF, CH_CR, CH_BS, CH_FF.
  - The state enum screen_wr_state_t.
- Single flat module; no RTL sub-module.
- The bench instantiates a dual-port model, screen_ram_dp: synchronous 1-cycle read, write on posedge.

## Test plan
- Reset, then send "AB": mem writes 0x41 to address 0 and 0x42 to address 1; cursor ends at (0,2); in_ready stays 1.
- Send 128 printables from (0,0): last write goes to address 127; cursor ends at (1,0); no scroll.
- Cursor at (79,5), send 0x0A: busy goes high for 10241 cycles.
  - Pre-seed row 1 with 0x55; after the scroll, row 0 holds 0x55.
  - Addresses 10112..10239 are 0x00.
  - Cursor ends at (79,0).
- Cursor at (3,0), send 0x08: no write, cursor unchanged. Cursor at (3,4), send 0x08: 0x00 written at address 387, cursor (3,3).
- Send 0x0C: 10240 zero writes at addresses 0..10239, in_ready=0 throughout, cursor ends at (0,0). Assert rst_n=0 midway: outputs clear immediately and in_ready returns to 1 after release.
- Hold in_valid high during a scroll: no byte is consumed until busy falls. The next byte is written at address 10112 (row 79, col 0).
